ahb3lite_ic_slave_port: RTL and testbench
=========================================

// Module: ahb3lite_ic_slave_port
// PURPOSE
// - Slave-side port of the AHB3-Lite multi-layer interconnect; one instance per slave.
// - Arbitrates between MASTERS master-port requests by priority, then round-robin on ties.
// - Muxes the granted master's address/control and the data-phase owner's HWDATA onto one slave.
// - Returns the slave's HRDATA/HREADY/HRESP to all masters, plus a one-hot grant vector.
// PARAMETERS
// HADDR_SIZE   32                                   address width
// HDATA_SIZE   32                                   data width
// MASTERS      3                                    number of master ports
// MASTER_BITS  MASTERS==1 ? 1 : $clog2(MASTERS)     priority width (derived; do not override)
// PORTS
// HCLK            in   1                          clock, rising edge
// HRESETn         in   1                          synchronous active-low reset
// mstpriority     in   [MASTERS][MASTER_BITS]     priority per master; larger value wins
// mstHSEL         in   [MASTERS]                  master m selects this slave
// mstHADDR        in   [MASTERS][HADDR_SIZE]      address per master
// mstHWDATA       in   [MASTERS][HDATA_SIZE]      write data per master
// mstHWRITE       in   [MASTERS]                  write per master
// mstHSIZE        in   [MASTERS][3]               size per master
// mstHBURST       in   [MASTERS][3]               burst per master
// mstHPROT        in   [MASTERS][4]               prot per master
// mstHTRANS       in   [MASTERS][2]               trans per master
// mstHMASTLOCK    in   [MASTERS]                  lock per master
// mstHREADY       in   [MASTERS]                  HREADY seen by each master port
// can_switch      in   [MASTERS]                  master m allows re-arbitration (not mid-burst/locked)
// mstHRDATA       out  HDATA_SIZE                 = slv_HRDATA
// mstHREADYOUT    out  1                          = slv_HREADY
// mstHRESP        out  1                          = slv_HRESP
// granted_master  out  [MASTERS]                  one-hot registered address-phase owner
// slv_HSEL/HADDR/HWRITE/HSIZE/HBURST/HPROT/HTRANS/HMASTLOCK  out  AHB widths  from granted master
// slv_HWDATA      out  HDATA_SIZE                 from data-phase owner
// slv_HREADYOUT   out  1                          = mstHREADY[granted]; drives slave HREADY
// slv_HRDATA      in   HDATA_SIZE                 slave read data
// slv_HREADY      in   1                          slave HREADYOUT
// slv_HRESP       in   1                          slave response
// BEHAVIOUR
// - Request: req[m] = mstHSEL[m] & (mstHTRANS[m] != IDLE 2'b00).
// - Arbitration permitted on an edge when slv_HREADY=1 and
//   (req[owner]=0 or can_switch[owner]=1); otherwise the grant holds.
// - Winner: max mstpriority among requesters.
//   Ties: round-robin, search starts at owner+1 and wraps modulo MASTERS.
//   No requesters: grant parks on the current owner.
// - The grant is registered, so a newly granted master's transfer reaches the slave the cycle after its request.
//   Master ports hold their transfer until granted_master[m]=1.
// - slv_HSEL = mstHSEL[owner] & req[owner].
//   slv_HTRANS = req[owner] ? mstHTRANS[owner] : IDLE.
//   Other address/control fields are a straight mux from owner.
// - Data-phase owner register: loads owner when slv_HREADY=1; slv_HWDATA = mstHWDATA[data_owner].
// - Reset (HRESETn=0 at an edge): owner = master 0 (granted_master = 1); data_owner = 0.
// - While HRESETn=0, slv_HSEL=0 and slv_HTRANS=IDLE are forced combinationally.
// - Return path is combinational with no added latency.
// - Simultaneous request and slv_HREADY=0: no re-arbitration; the decision is retried every ready cycle.
// - MASTERS=1: always granted; priority ignored.
// TESTING
// - Reset, then master 1 req (HTRANS=NONSEQ, HADDR=0x100) -> next cycle granted_master=3'b010, slv_HADDR=0x100, slv_HTRANS=2'b10.
// - M0 prio 0 and M2 prio 2 request together -> M2 granted; M0 granted once M2 goes IDLE.
// - Equal priorities, all 3 request continuously, can_switch=1 -> grants rotate 0->1->2->0.
// - Owner mid-burst with can_switch=0 while higher-priority master requests -> grant unchanged until can_switch=1.
// - slv_HREADY=0 for 2 cycles -> grant and data_owner frozen; mstHREADYOUT=0; HWDATA from previous owner.
// - Write by M1 then read by M2 back-to-back -> slv_HWDATA=mstHWDATA[1] in M1 data phase; mstHRDATA=slv_HRDATA.

Source files
------------

// File: rtl/ahb3lite_ic_slave_port_if.sv
// Bus bundle between the master ports of the interconnect and one slave port.
// Carries every master's address/control/data and priority, the slave-side
// address/control/data, and the shared return path.
//   slave  modport : view taken by ahb3lite_ic_slave_port
//   master modport : view taken by the surrounding fabric / bench
interface ahb3lite_ic_slave_port_if #(
    parameter int unsigned HADDR_SIZE = 32,
    parameter int unsigned HDATA_SIZE = 32,
    parameter int unsigned MASTERS    = 3
);
    localparam int unsigned MASTER_BITS = (MASTERS == 1) ? 1 : $clog2(MASTERS);

    // master-port side
    logic [MASTERS-1:0][MASTER_BITS-1:0] mstpriority;
    logic [MASTERS-1:0]                  mstHSEL;
    logic [MASTERS-1:0][HADDR_SIZE-1:0]  mstHADDR;
    logic [MASTERS-1:0][HDATA_SIZE-1:0]  mstHWDATA;
    logic [MASTERS-1:0]                  mstHWRITE;
    logic [MASTERS-1:0][2:0]             mstHSIZE;
    logic [MASTERS-1:0][2:0]             mstHBURST;
    logic [MASTERS-1:0][3:0]             mstHPROT;
    logic [MASTERS-1:0][1:0]             mstHTRANS;
    logic [MASTERS-1:0]                  mstHMASTLOCK;
    logic [MASTERS-1:0]                  mstHREADY;
    logic [MASTERS-1:0]                  can_switch;
    logic [HDATA_SIZE-1:0]               mstHRDATA;
    logic                                mstHREADYOUT;
    logic                                mstHRESP;
    logic [MASTERS-1:0]                  granted_master;

    // slave side
    logic                                slv_HSEL;
    logic [HADDR_SIZE-1:0]               slv_HADDR;
    logic [HDATA_SIZE-1:0]               slv_HWDATA;
    logic                                slv_HWRITE;
    logic [2:0]                          slv_HSIZE;
    logic [2:0]                          slv_HBURST;
    logic [3:0]                          slv_HPROT;
    logic [1:0]                          slv_HTRANS;
    logic                                slv_HMASTLOCK;
    logic                                slv_HREADYOUT;
    logic [HDATA_SIZE-1:0]               slv_HRDATA;
    logic                                slv_HREADY;
    logic                                slv_HRESP;

    modport slave (
        input  mstpriority, mstHSEL, mstHADDR, mstHWDATA, mstHWRITE, mstHSIZE,
               mstHBURST, mstHPROT, mstHTRANS, mstHMASTLOCK, mstHREADY, can_switch,
               slv_HRDATA, slv_HREADY, slv_HRESP,
        output mstHRDATA, mstHREADYOUT, mstHRESP, granted_master,
               slv_HSEL, slv_HADDR, slv_HWDATA, slv_HWRITE, slv_HSIZE, slv_HBURST,
               slv_HPROT, slv_HTRANS, slv_HMASTLOCK, slv_HREADYOUT
    );

    modport master (
        output mstpriority, mstHSEL, mstHADDR, mstHWDATA, mstHWRITE, mstHSIZE,
               mstHBURST, mstHPROT, mstHTRANS, mstHMASTLOCK, mstHREADY, can_switch,
               slv_HRDATA, slv_HREADY, slv_HRESP,
        input  mstHRDATA, mstHREADYOUT, mstHRESP, granted_master,
               slv_HSEL, slv_HADDR, slv_HWDATA, slv_HWRITE, slv_HSIZE, slv_HBURST,
               slv_HPROT, slv_HTRANS, slv_HMASTLOCK, slv_HREADYOUT
    );
endinterface

// File: rtl/ahb3lite_ic_slave_port.sv
// Slave-side port of the AHB3-Lite multi-layer interconnect (one per slave).
// Arbitrates the master-port requests (highest priority wins, round-robin on
// ties), muxes the address-phase owner's control and the data-phase owner's
// write data onto the slave, and fans the slave response back to all masters.
//   HCLK    : clock, rising edge
//   HRESETn : synchronous active-low reset
//   bus     : ahb3lite_ic_slave_port_if.slave (all master and slave signals)
module ahb3lite_ic_slave_port #(
    parameter int unsigned HADDR_SIZE = 32,
    parameter int unsigned HDATA_SIZE = 32,
    parameter int unsigned MASTERS    = 3
) (
    input  logic                      HCLK,
    input  logic                      HRESETn,
    ahb3lite_ic_slave_port_if.slave   bus
);
    localparam int unsigned MASTER_BITS = (MASTERS == 1) ? 1 : $clog2(MASTERS);
    localparam logic [1:0]  HTRANS_IDLE = 2'b00;

    logic [MASTERS-1:0]     req;
    logic [MASTER_BITS-1:0] owner;
    logic [MASTER_BITS-1:0] owner_nxt;
    logic [MASTER_BITS-1:0] data_owner;
    logic [MASTERS-1:0]     grant_q;
    logic [MASTERS-1:0]     grant_nxt;
    logic [MASTER_BITS-1:0] winner;
    logic [MASTER_BITS-1:0] best_prio;
    logic [MASTER_BITS-1:0] cand;
    logic                   found;
    logic                   arb_ok;
    int                     cand_int;

    // A master requests when it selects this slave with a non-IDLE transfer
    always_comb begin
        req = '0;
        for (int m = 0; m < int'(MASTERS); m++) begin
            req[m] = bus.mstHSEL[m] & (bus.mstHTRANS[m] != HTRANS_IDLE);
        end
    end

    // Priority arbiter; scanning from owner+1 with strict '>' makes the first
    // max-priority requester after the owner win, i.e. round-robin on ties.
    // The owner itself is visited last so it only keeps the bus on a tie
    // when nobody after it matches.
    always_comb begin
        found     = 1'b0;
        best_prio = '0;
        winner    = owner;
        cand_int  = 0;
        cand      = '0;
        for (int i = 1; i <= int'(MASTERS); i++) begin
            cand_int = int'(owner) + i;
            if (cand_int >= int'(MASTERS)) cand_int = cand_int - int'(MASTERS);
            cand = MASTER_BITS'(cand_int);
            if (req[cand] && (!found || (bus.mstpriority[cand] > best_prio))) begin
                found     = 1'b1;
                best_prio = bus.mstpriority[cand];
                winner    = cand;
            end
        end
        // No requesters: winner stays at owner, so the grant parks
        arb_ok    = bus.slv_HREADY & (~req[owner] | bus.can_switch[owner]);
        owner_nxt = arb_ok ? winner : owner;
        grant_nxt = '0;
        grant_nxt[owner_nxt] = 1'b1;
    end

    // Address-phase and data-phase owner registers
    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            owner      <= '0;
            grant_q    <= MASTERS'(1);
            data_owner <= '0;
        end else begin
            owner   <= owner_nxt;
            grant_q <= grant_nxt;
            if (bus.slv_HREADY) data_owner <= owner;
        end
    end

    // Slave-side mux; select and transfer type are suppressed while in reset
    assign bus.slv_HSEL      = HRESETn & bus.mstHSEL[owner] & req[owner];
    assign bus.slv_HTRANS    = (HRESETn && req[owner]) ? bus.mstHTRANS[owner] : HTRANS_IDLE;
    assign bus.slv_HADDR     = bus.mstHADDR[owner];
    assign bus.slv_HWRITE    = bus.mstHWRITE[owner];
    assign bus.slv_HSIZE     = bus.mstHSIZE[owner];
    assign bus.slv_HBURST    = bus.mstHBURST[owner];
    assign bus.slv_HPROT     = bus.mstHPROT[owner];
    assign bus.slv_HMASTLOCK = bus.mstHMASTLOCK[owner];
    assign bus.slv_HREADYOUT = bus.mstHREADY[owner];
    assign bus.slv_HWDATA    = bus.mstHWDATA[data_owner];

    // Return path, shared by all masters
    assign bus.mstHRDATA      = bus.slv_HRDATA;
    assign bus.mstHREADYOUT   = bus.slv_HREADY;
    assign bus.mstHRESP       = bus.slv_HRESP;
    assign bus.granted_master = grant_q;
endmodule

// File: tb/tb_ahb3lite_ic_slave_port.sv
// Directed bench for ahb3lite_ic_slave_port (3 masters, 32-bit bus).
module tb_ahb3lite_ic_slave_port;
    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned NM = 3;

    logic HCLK;
    logic HRESETn;
    int   checks;
    int   errors;

    ahb3lite_ic_slave_port_if #(.HADDR_SIZE(AW), .HDATA_SIZE(DW), .MASTERS(NM)) bus ();

    ahb3lite_ic_slave_port #(.HADDR_SIZE(AW), .HDATA_SIZE(DW), .MASTERS(NM)) dut (
        .HCLK    (HCLK),
        .HRESETn (HRESETn),
        .bus     (bus)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    // Advance one rising edge; inputs are driven and outputs sampled 1ns later
    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    task automatic set_idle();
        bus.mstHSEL    = '0;
        bus.mstHTRANS  = '0;
        bus.mstpriority = '0;
        bus.can_switch = '1;
        bus.mstHREADY  = '1;
        bus.slv_HREADY = 1'b1;
    endtask

    task automatic test_reset();
        HRESETn = 1'b0;
        set_idle();
        bus.mstHWRITE = '0; bus.mstHSIZE = '0; bus.mstHBURST = '0;
        bus.mstHPROT = '0; bus.mstHMASTLOCK = '0; bus.mstHADDR = '0;
        bus.mstHWDATA[0] = 32'hA0A0_0000;
        bus.mstHWDATA[1] = 32'hA1A1_1111;
        bus.mstHWDATA[2] = 32'hA2A2_2222;
        bus.slv_HRDATA = '0;
        bus.slv_HRESP  = 1'b0;
        // M0 requests during reset: slave select must still be forced off
        bus.mstHSEL[0] = 1'b1;
        bus.mstHTRANS[0] = 2'b10;
        tick();
        tick();
        checks++;
        if (bus.granted_master !== 3'b001) begin
            errors++; $display("FAIL reset_grant: got %b expected 001", bus.granted_master);
        end
        checks++;
        if (bus.slv_HSEL !== 1'b0) begin
            errors++; $display("FAIL reset_hsel: got %b expected 0", bus.slv_HSEL);
        end
        checks++;
        if (bus.slv_HTRANS !== 2'b00) begin
            errors++; $display("FAIL reset_htrans: got %b expected 00", bus.slv_HTRANS);
        end
        HRESETn = 1'b1;
        set_idle();
        tick();
    endtask

    task automatic test_single_request();
        bus.mstHSEL[1] = 1'b1;
        bus.mstHTRANS[1] = 2'b10;
        bus.mstHADDR[1] = 32'h0000_0100;
        #1;
        checks++;
        if (bus.slv_HSEL !== 1'b0) begin
            errors++; $display("FAIL single_pre_hsel: got %b expected 0", bus.slv_HSEL);
        end
        tick();
        checks++;
        if (bus.granted_master !== 3'b010) begin
            errors++; $display("FAIL single_grant: got %b expected 010", bus.granted_master);
        end
        checks++;
        if (bus.slv_HADDR !== 32'h0000_0100) begin
            errors++; $display("FAIL single_haddr: got %h expected 00000100", bus.slv_HADDR);
        end
        checks++;
        if (bus.slv_HTRANS !== 2'b10 || bus.slv_HSEL !== 1'b1) begin
            errors++; $display("FAIL single_htrans: got %b/%b expected 10/1", bus.slv_HTRANS, bus.slv_HSEL);
        end
        set_idle();
        tick();
        checks++;
        if (bus.granted_master !== 3'b010) begin
            errors++; $display("FAIL park_grant: got %b expected 010", bus.granted_master);
        end
    endtask

    task automatic test_priority();
        set_idle();
        bus.mstpriority[2] = 2'd2;
        bus.mstHSEL[0] = 1'b1; bus.mstHTRANS[0] = 2'b10; bus.mstHADDR[0] = 32'h0000_0000;
        bus.mstHSEL[2] = 1'b1; bus.mstHTRANS[2] = 2'b10; bus.mstHADDR[2] = 32'h0000_0220;
        tick();
        checks++;
        if (bus.granted_master !== 3'b100 || bus.slv_HADDR !== 32'h0000_0220) begin
            errors++; $display("FAIL prio_win: got %b/%h expected 100/00000220", bus.granted_master, bus.slv_HADDR);
        end
        bus.mstHTRANS[2] = 2'b11;
        tick();
        checks++;
        if (bus.granted_master !== 3'b100) begin
            errors++; $display("FAIL prio_hold: got %b expected 100", bus.granted_master);
        end
        bus.mstHTRANS[2] = 2'b00;
        tick();
        checks++;
        if (bus.granted_master !== 3'b001) begin
            errors++; $display("FAIL prio_low: got %b expected 001", bus.granted_master);
        end
    endtask

    task automatic test_round_robin();
        logic [NM-1:0] exp_seq [4];
        exp_seq[0] = 3'b010; exp_seq[1] = 3'b100; exp_seq[2] = 3'b001; exp_seq[3] = 3'b010;
        set_idle();
        bus.mstHSEL = '1;
        for (int m = 0; m < int'(NM); m++) bus.mstHTRANS[m] = 2'b10;
        for (int k = 0; k < 4; k++) begin
            tick();
            checks++;
            if (bus.granted_master !== exp_seq[k]) begin
                errors++; $display("FAIL rr_step%0d: got %b expected %b", k, bus.granted_master, exp_seq[k]);
            end
        end
    endtask

    task automatic test_can_switch();
        set_idle();
        bus.mstHSEL[1] = 1'b1; bus.mstHTRANS[1] = 2'b11;
        bus.mstHSEL[2] = 1'b1; bus.mstHTRANS[2] = 2'b10;
        bus.mstpriority[2] = 2'd2;
        bus.can_switch[1] = 1'b0;
        for (int k = 0; k < 2; k++) begin
            tick();
            checks++;
            if (bus.granted_master !== 3'b010) begin
                errors++; $display("FAIL lock_hold%0d: got %b expected 010", k, bus.granted_master);
            end
        end
        bus.can_switch[1] = 1'b1;
        tick();
        checks++;
        if (bus.granted_master !== 3'b100) begin
            errors++; $display("FAIL lock_release: got %b expected 100", bus.granted_master);
        end
    endtask

    task automatic test_ready_stall();
        // owner M2, data owner M1 on entry
        set_idle();
        bus.mstHSEL[0] = 1'b1; bus.mstHTRANS[0] = 2'b10;
        bus.mstHREADY[2] = 1'b0;
        bus.slv_HREADY = 1'b0;
        #1;
        checks++;
        if (bus.mstHREADYOUT !== 1'b0 || bus.slv_HREADYOUT !== 1'b0) begin
            errors++; $display("FAIL stall_ready: got %b/%b expected 0/0", bus.mstHREADYOUT, bus.slv_HREADYOUT);
        end
        for (int k = 0; k < 2; k++) begin
            tick();
            checks++;
            if (bus.granted_master !== 3'b100 || bus.slv_HWDATA !== 32'hA1A1_1111) begin
                errors++; $display("FAIL stall_freeze%0d: got %b/%h expected 100/a1a11111", k, bus.granted_master, bus.slv_HWDATA);
            end
        end
        bus.slv_HREADY = 1'b1;
        bus.mstHREADY[2] = 1'b1;
        tick();
        checks++;
        if (bus.granted_master !== 3'b001 || bus.slv_HWDATA !== 32'hA2A2_2222) begin
            errors++; $display("FAIL stall_resume: got %b/%h expected 001/a2a22222", bus.granted_master, bus.slv_HWDATA);
        end
    endtask

    task automatic test_back_to_back();
        set_idle();
        bus.mstHSEL[1] = 1'b1; bus.mstHTRANS[1] = 2'b10;
        bus.mstHADDR[1] = 32'h0000_0200; bus.mstHWRITE[1] = 1'b1;
        tick();
        checks++;
        if (bus.slv_HADDR !== 32'h0000_0200 || bus.slv_HWRITE !== 1'b1) begin
            errors++; $display("FAIL b2b_write_addr: got %h/%b expected 00000200/1", bus.slv_HADDR, bus.slv_HWRITE);
        end
        bus.mstHSEL[1] = 1'b0; bus.mstHTRANS[1] = 2'b00;
        bus.mstHSEL[2] = 1'b1; bus.mstHTRANS[2] = 2'b10;
        bus.mstHADDR[2] = 32'h0000_0300; bus.mstHWRITE[2] = 1'b0;
        bus.mstHSIZE[2] = 3'b010; bus.mstHBURST[2] = 3'b011;
        bus.mstHPROT[2] = 4'hA; bus.mstHMASTLOCK[2] = 1'b1;
        tick();
        checks++;
        if (bus.slv_HWDATA !== 32'hA1A1_1111) begin
            errors++; $display("FAIL b2b_hwdata: got %h expected a1a11111", bus.slv_HWDATA);
        end
        checks++;
        if (bus.slv_HADDR !== 32'h0000_0300 || bus.slv_HWRITE !== 1'b0) begin
            errors++; $display("FAIL b2b_read_addr: got %h/%b expected 00000300/0", bus.slv_HADDR, bus.slv_HWRITE);
        end
        checks++;
        if (bus.slv_HSIZE !== 3'b010 || bus.slv_HBURST !== 3'b011 ||
            bus.slv_HPROT !== 4'hA || bus.slv_HMASTLOCK !== 1'b1) begin
            errors++; $display("FAIL b2b_ctrl: got %b/%b/%h/%b expected 010/011/a/1",
                               bus.slv_HSIZE, bus.slv_HBURST, bus.slv_HPROT, bus.slv_HMASTLOCK);
        end
        bus.slv_HRDATA = 32'hDEAD_BEEF;
        bus.slv_HRESP  = 1'b1;
        #1;
        checks++;
        if (bus.mstHRDATA !== 32'hDEAD_BEEF || bus.mstHRESP !== 1'b1) begin
            errors++; $display("FAIL b2b_return: got %h/%b expected deadbeef/1", bus.mstHRDATA, bus.mstHRESP);
        end
        bus.slv_HRESP = 1'b0;
        bus.mstHSEL[2] = 1'b0; bus.mstHTRANS[2] = 2'b00;
        tick();
        checks++;
        if (bus.slv_HWDATA !== 32'hA2A2_2222 || bus.granted_master !== 3'b100) begin
            errors++; $display("FAIL b2b_tail: got %h/%b expected a2a22222/100", bus.slv_HWDATA, bus.granted_master);
        end
        checks++;
        if (bus.slv_HSEL !== 1'b0 || bus.slv_HTRANS !== 2'b00) begin
            errors++; $display("FAIL b2b_park_idle: got %b/%b expected 0/00", bus.slv_HSEL, bus.slv_HTRANS);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_single_request();
        test_priority();
        test_round_robin();
        test_can_switch();
        test_ready_stall();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
